// File: rtl/irq_ctrl.sv
// Priority interrupt controller: latches peripheral requests, applies a mask,
// issues a one-cycle take pulse with vector, and tracks nesting through a
// small hardware stack that is popped on IRET.
module irq_ctrl #(
    parameter int unsigned N_IRQ      = 8,
    parameter logic [15:0] VEC_BASE   = 16'h0100,
    parameter int unsigned VEC_STRIDE = 4,
    parameter int unsigned MAX_DEPTH  = 3,
    parameter int unsigned HOLD_CYC   = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_IRQ-1:0] i_irq_req,
    input  logic             i_int_en,
    input  logic             i_insn_ce,
    input  logic             i_iret,
    input  logic             i_cfg_we,
    input  logic [1:0]       i_cfg_addr,
    input  logic [15:0]      i_cfg_wdata,
    output logic [15:0]      o_cfg_rdata,
    output logic             o_irq_take,
    output logic [15:0]      o_irq_vector,
    output logic [3:0]       o_irq_id,
    output logic [1:0]       o_depth,
    output logic             o_iret_err
);

    typedef enum logic [1:0] {StIdle, StTake, StHold} state_e;

    state_e           r_state;
    logic             r_take;
    logic [15:0]      r_vector;
    logic [3:0]       r_id;
    logic [7:0]       r_hold_cnt;
    logic [N_IRQ-1:0] r_mask;
    logic [N_IRQ-1:0] r_pend;
    logic [N_IRQ-1:0] r_active;
    logic [N_IRQ-1:0] r_req_prev;
    logic [3:0]       r_stack [4];
    logic [1:0]       r_depth;
    logic             r_iret_err;

    logic [N_IRQ-1:0] w_wdata;
    logic [15:0]      w_wdata_unused;
    logic [N_IRQ-1:0] w_src;
    logic [3:0]       w_cand;
    logic [N_IRQ-1:0] w_cand_oh;
    logic             w_cand_vld;
    logic [3:0]       w_act_low;
    logic             w_act_any;
    logic             w_depth_ok;
    logic             w_take_go;
    logic [15:0]      w_vec;
    logic             w_iret_pop;
    logic [3:0]       w_top;
    logic [N_IRQ-1:0] w_top_oh;
    logic [1:0]       w_depth_pop;
    logic [N_IRQ-1:0] w_pend_set;
    logic [N_IRQ-1:0] w_pend_clr;
    logic [N_IRQ-1:0] w_act_clr;
    logic [N_IRQ-1:0] w_act_set;
    logic [15:0]      w_rdata;

    assign w_wdata        = i_cfg_wdata[N_IRQ-1:0];
    // Upper write-data bits beyond N_IRQ carry no meaning
    assign w_wdata_unused = i_cfg_wdata;
    assign w_src          = r_pend & r_mask;
    assign w_depth_ok     = ({30'd0, r_depth} < MAX_DEPTH);
    assign w_vec          = VEC_BASE + 16'(w_cand) * 16'(VEC_STRIDE);
    assign w_iret_pop     = i_iret && (r_depth != 2'd0);
    assign w_top          = r_stack[r_depth - 2'd1];
    assign w_depth_pop    = r_depth - {1'b0, w_iret_pop};

    // Priority search: lowest pending+enabled index and lowest active index
    always_comb begin
        w_cand     = '0;
        w_cand_oh  = '0;
        w_cand_vld = 1'b0;
        w_act_low  = '0;
        w_act_any  = 1'b0;
        w_top_oh   = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_src[i]) begin
                w_cand     = 4'(i);
                w_cand_oh  = '0;
                w_cand_oh[i] = 1'b1;
                w_cand_vld = 1'b1;
            end
            if (r_active[i]) begin
                w_act_low = 4'(i);
                w_act_any = 1'b1;
            end
            if (4'(i) == w_top) begin
                w_top_oh[i] = 1'b1;
            end
        end
    end

    // Take decision: strict preemption only, bounded by stack depth
    assign w_take_go = (r_state == StIdle) && i_int_en && i_insn_ce && w_cand_vld &&
                       w_depth_ok && (!w_act_any || (w_cand < w_act_low));

    // Pending/active set and clear terms; a set beats a same-cycle clear
    always_comb begin
        w_pend_set = i_irq_req & ~r_req_prev;
        w_pend_clr = '0;
        w_act_clr  = '0;
        w_act_set  = '0;
        if (i_cfg_we && i_cfg_addr == 2'd3) w_pend_set = w_pend_set | w_wdata;
        if (i_cfg_we && i_cfg_addr == 2'd1) w_pend_clr = w_wdata;
        if (w_take_go) begin
            w_pend_clr = w_pend_clr | w_cand_oh;
            w_act_set  = w_cand_oh;
        end
        if (w_iret_pop) w_act_clr = w_top_oh;
    end

    // Register read mux, zero-extended; SWSET reads as 0
    always_comb begin
        w_rdata = '0;
        case (i_cfg_addr)
            2'd0:    w_rdata[N_IRQ-1:0] = r_mask;
            2'd1:    w_rdata[N_IRQ-1:0] = r_pend;
            2'd2:    w_rdata[N_IRQ-1:0] = r_active;
            default: w_rdata = '0;
        endcase
    end

    // Take sequencing FSM with registered take pulse, id and vector
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_take     <= 1'b0;
            r_vector   <= '0;
            r_id       <= '0;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_take_go) begin
                        r_state  <= StTake;
                        r_take   <= 1'b1;
                        r_id     <= w_cand;
                        r_vector <= w_vec;
                    end
                end
                StTake: begin
                    r_take     <= 1'b0;
                    r_hold_cnt <= 8'(HOLD_CYC);
                    r_state    <= (HOLD_CYC == 0) ? StIdle : StHold;
                end
                StHold: begin
                    if (r_hold_cnt <= 8'd1) begin
                        r_hold_cnt <= '0;
                        r_state    <= StIdle;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_take  <= 1'b0;
                end
            endcase
        end
    end

    // Pending, mask, active set, nesting stack and IRET error flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mask     <= '0;
            r_pend     <= '0;
            r_active   <= '0;
            r_req_prev <= '0;
            r_depth    <= '0;
            r_iret_err <= 1'b0;
            for (int i = 0; i < 4; i++) r_stack[i] <= '0;
        end else begin
            r_req_prev <= i_irq_req;
            r_pend     <= (r_pend & ~w_pend_clr) | w_pend_set;
            r_active   <= (r_active & ~w_act_clr) | w_act_set;
            if (i_cfg_we && i_cfg_addr == 2'd0) r_mask <= w_wdata;
            // Pop applies first, so a same-edge push overwrites the popped slot
            if (w_take_go) r_stack[w_depth_pop] <= w_cand;
            r_depth <= w_depth_pop + {1'b0, w_take_go};
            if (i_iret && r_depth == 2'd0) r_iret_err <= 1'b1;
        end
    end

    assign o_cfg_rdata  = w_rdata;
    assign o_irq_take   = r_take;
    assign o_irq_vector = r_vector;
    assign o_irq_id     = r_id;
    assign o_depth      = r_depth;
    assign o_iret_err   = r_iret_err;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: register vector table plus take/nesting sequences.
module tb_irq_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [7:0]  i_irq_req = '0;
    logic        i_int_en = 1'b0;
    logic        i_insn_ce = 1'b0;
    logic        i_iret = 1'b0;
    logic        i_cfg_we = 1'b0;
    logic [1:0]  i_cfg_addr = '0;
    logic [15:0] i_cfg_wdata = '0;
    logic [15:0] o_cfg_rdata;
    logic        o_irq_take;
    logic [15:0] o_irq_vector;
    logic [3:0]  o_irq_id;
    logic [1:0]  o_depth;
    logic        o_iret_err;

    int n_tests = 0;
    int n_fail  = 0;

    irq_ctrl dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_irq_req   (i_irq_req),
        .i_int_en    (i_int_en),
        .i_insn_ce   (i_insn_ce),
        .i_iret      (i_iret),
        .i_cfg_we    (i_cfg_we),
        .i_cfg_addr  (i_cfg_addr),
        .i_cfg_wdata (i_cfg_wdata),
        .o_cfg_rdata (o_cfg_rdata),
        .o_irq_take  (o_irq_take),
        .o_irq_vector(o_irq_vector),
        .o_irq_id    (o_irq_id),
        .o_depth     (o_depth),
        .o_iret_err  (o_iret_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        we;
        logic [1:0]  waddr;
        logic [15:0] wdata;
        logic [1:0]  raddr;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [15:0] d);
        i_cfg_addr = a;
        #1;
        d = o_cfg_rdata;
    endtask

    task automatic check_reg(input string name, input logic [1:0] a, input logic [15:0] exp);
        logic [15:0] d;
        rd(a, d);
        check(name, d, exp);
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [15:0] d);
        i_cfg_we    = 1'b1;
        i_cfg_addr  = a;
        i_cfg_wdata = d;
        step();
        i_cfg_we = 1'b0;
    endtask

    task automatic pulse_req(input int idx);
        i_irq_req[idx] = 1'b1;
        step();
        i_irq_req[idx] = 1'b0;
    endtask

    task automatic do_iret();
        i_iret = 1'b1;
        step();
        i_iret = 1'b0;
    endtask

    task automatic hold_wait();
        repeat (4) step();
    endtask

    // Bounded wait for a take pulse; leaves the bench on the take cycle
    task automatic wait_take(input string name, input int bound);
        logic found;
        found = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (o_irq_take) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check(name, 16'(found), 16'd1);
    endtask

    task automatic no_take(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (o_irq_take) seen = 1'b1;
            step();
        end
        check(name, 16'(seen), 16'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 2'd0, 16'hFF0F, 2'd0, 16'h000F};
        vecs[1] = '{1'b1, 2'd3, 16'h00A5, 2'd1, 16'h00A5};
        vecs[2] = '{1'b1, 2'd1, 16'h0021, 2'd1, 16'h0084};
        vecs[3] = '{1'b1, 2'd2, 16'h00FF, 2'd2, 16'h0000};
        vecs[4] = '{1'b0, 2'd0, 16'h0000, 2'd3, 16'h0000};
        vecs[5] = '{1'b1, 2'd3, 16'hFF00, 2'd1, 16'h0084};
        vecs[6] = '{1'b1, 2'd1, 16'h00FF, 2'd1, 16'h0000};
        vecs[7] = '{1'b1, 2'd0, 16'h00FF, 2'd0, 16'h00FF};

        // Reset values
        step();
        step();
        i_rst = 1'b0;
        check("rst_take", 16'(o_irq_take), 16'd0);
        check("rst_vector", o_irq_vector, 16'h0000);
        check("rst_id", 16'(o_irq_id), 16'd0);
        check("rst_depth", 16'(o_depth), 16'd0);
        check("rst_iret_err", 16'(o_iret_err), 16'd0);
        check_reg("rst_mask", 2'd0, 16'h0000);
        check_reg("rst_pend", 2'd1, 16'h0000);
        check_reg("rst_active", 2'd2, 16'h0000);

        // Register table with interrupts disabled
        for (int k = 0; k < 8; k++) begin
            logic [15:0] d;
            if (vecs[k].we) cfg_wr(vecs[k].waddr, vecs[k].wdata);
            rd(vecs[k].raddr, d);
            check($sformatf("cfg_vec%0d", k), d, vecs[k].exp);
        end

        // Basic take latency, vector, depth and ACTIVE
        i_int_en  = 1'b1;
        i_insn_ce = 1'b1;
        pulse_req(3);
        check("t1_no_early_take", 16'(o_irq_take), 16'd0);
        step();
        check("t1_take", 16'(o_irq_take), 16'd1);
        check("t1_id", 16'(o_irq_id), 16'd3);
        check("t1_vector", o_irq_vector, 16'h010C);
        check("t1_depth", 16'(o_depth), 16'd1);
        check_reg("t1_active", 2'd2, 16'h0008);
        step();
        check("t1_take_one_cycle", 16'(o_irq_take), 16'd0);
        hold_wait();
        do_iret();
        check("t1_iret_depth", 16'(o_depth), 16'd0);
        check_reg("t1_iret_active", 2'd2, 16'h0000);

        // Simultaneous requests: priority order, lower one stays pending
        i_irq_req[5] = 1'b1;
        i_irq_req[2] = 1'b1;
        step();
        i_irq_req = '0;
        wait_take("t2_take_a", 4);
        check("t2_id_a", 16'(o_irq_id), 16'd2);
        check_reg("t2_pend", 2'd1, 16'h0020);
        i_int_en = 1'b0;
        step();
        hold_wait();
        do_iret();
        check("t2_depth0", 16'(o_depth), 16'd0);
        no_take("t2_no_take_int_dis", 4);
        i_int_en = 1'b1;
        wait_take("t2_take_b", 6);
        check("t2_id_b", 16'(o_irq_id), 16'd5);
        check("t2_vector_b", o_irq_vector, 16'h0114);
        hold_wait();
        do_iret();

        // Preemption and its refusal
        pulse_req(4);
        wait_take("t3_take4", 4);
        hold_wait();
        pulse_req(1);
        wait_take("t3_take1", 4);
        check("t3_id1", 16'(o_irq_id), 16'd1);
        check("t3_depth2", 16'(o_depth), 16'd2);
        check_reg("t3_active", 2'd2, 16'h0012);
        hold_wait();
        do_iret();
        do_iret();
        check("t3_depth0", 16'(o_depth), 16'd0);
        pulse_req(1);
        wait_take("t3_take1b", 4);
        hold_wait();
        pulse_req(6);
        no_take("t3_no_preempt6", 8);
        check_reg("t3_pend6", 2'd1, 16'h0040);
        do_iret();
        wait_take("t3_take6", 6);
        check("t3_id6", 16'(o_irq_id), 16'd6);
        hold_wait();
        do_iret();

        // Three-level nesting, depth limit, pop order
        pulse_req(6);
        wait_take("t4_take6", 4);
        hold_wait();
        pulse_req(3);
        wait_take("t4_take3", 4);
        hold_wait();
        pulse_req(0);
        wait_take("t4_take0", 4);
        check("t4_vector0", o_irq_vector, 16'h0100);
        check("t4_depth3", 16'(o_depth), 16'd3);
        check_reg("t4_active", 2'd2, 16'h0049);
        hold_wait();
        pulse_req(1);
        no_take("t4_full_no_take", 8);
        check_reg("t4_pend1", 2'd1, 16'h0002);
        cfg_wr(2'd1, 16'h0002);
        do_iret();
        check("t4_pop0_depth", 16'(o_depth), 16'd2);
        check_reg("t4_pop0_active", 2'd2, 16'h0048);
        do_iret();
        check("t4_pop3_depth", 16'(o_depth), 16'd1);
        check_reg("t4_pop3_active", 2'd2, 16'h0040);
        do_iret();
        check("t4_pop6_depth", 16'(o_depth), 16'd0);
        check_reg("t4_pop6_active", 2'd2, 16'h0000);

        // IRET at depth 0, and IRET on the take-commit edge
        check("t5_err_clear", 16'(o_iret_err), 16'd0);
        do_iret();
        check("t5_err_set", 16'(o_iret_err), 16'd1);
        check("t5_depth_still0", 16'(o_depth), 16'd0);
        pulse_req(4);
        wait_take("t5_take4", 4);
        hold_wait();
        pulse_req(1);
        i_iret = 1'b1;
        step();
        i_iret = 1'b0;
        check("t5_same_edge_take", 16'(o_irq_take), 16'd1);
        check("t5_same_edge_id", 16'(o_irq_id), 16'd1);
        check("t5_same_edge_depth", 16'(o_depth), 16'd1);
        check_reg("t5_same_edge_active", 2'd2, 16'h0002);
        hold_wait();
        do_iret();
        check_reg("t5_final_active", 2'd2, 16'h0000);
        check("t5_err_sticky", 16'(o_iret_err), 16'd1);

        // Software set against mask, then W1C racing a request edge
        cfg_wr(2'd0, 16'h00EF);
        cfg_wr(2'd3, 16'h0010);
        no_take("t6_masked_no_take", 8);
        check_reg("t6_pend4", 2'd1, 16'h0010);
        cfg_wr(2'd0, 16'h00FF);
        wait_take("t6_take4", 6);
        check("t6_id4", 16'(o_irq_id), 16'd4);
        hold_wait();
        do_iret();
        i_int_en     = 1'b0;
        i_irq_req[5] = 1'b1;
        i_cfg_we     = 1'b1;
        i_cfg_addr   = 2'd1;
        i_cfg_wdata  = 16'h0020;
        step();
        i_cfg_we  = 1'b0;
        i_irq_req = '0;
        check_reg("t6_set_wins", 2'd1, 16'h0020);
        cfg_wr(2'd1, 16'h0020);
        check_reg("t6_w1c", 2'd1, 16'h0000);

        // Reset mid-sequence discards the in-flight take
        i_int_en = 1'b1;
        pulse_req(2);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        no_take("t7_no_take_after_rst", 6);
        check_reg("t7_pend", 2'd1, 16'h0000);
        check_reg("t7_mask", 2'd0, 16'h0000);
        check("t7_depth", 16'(o_depth), 16'd0);
        check("t7_err", 16'(o_iret_err), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
